// File: rtl/pixel_processor.sv
// pixel_processor: input FIFO, per-frame selectable pixel operation and a
// registered valid/ready output stage with line/frame markers.
module pixel_processor #(
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       sensor_clk,
  input  logic       rst_n,
  input  logic [7:0] in_pixel,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] mode,
  input  logic [7:0] threshold,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic       frame_done,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   READY_LVL = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_GRAD   = 2'd3
  } mode_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          fifo_empty, fifo_full, push, pop;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          first_pix, last_col, last_row;
  mode_t         active_mode, cur_mode;
  logic [7:0]    active_thr, cur_thr;
  logic [7:0]    prev_pixel, head, result;
  logic          out_last;

  // FIFO status, handshake decisions and the pixel operation on the head entry
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_LVL);
    pop        = !fifo_empty && (!out_valid || out_ready);
    // A pop in the same edge frees the slot, so a push into a full FIFO is kept
    push       = in_valid && (!fifo_full || pop);
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    head       = mem[rd_ptr];
    first_pix  = (col == '0) && (row == '0);
    last_col   = (col == LAST_COL);
    last_row   = (row == LAST_ROW);
    // The first pixel of a frame already uses the settings being latched now
    cur_mode   = first_pix ? mode_t'(mode) : active_mode;
    cur_thr    = first_pix ? threshold : active_thr;
    result     = head;
    case (cur_mode)
      MODE_BYPASS: result = head;
      MODE_INVERT: result = ~head;
      MODE_THRESH: result = (head >= cur_thr) ? 8'hFF : 8'h00;
      MODE_GRAD: begin
        if (col == '0)
          result = 8'h00;
        else if (head >= prev_pixel)
          result = head - prev_pixel;
        else
          result = prev_pixel - head;
      end
      default: result = head;
    endcase
  end

  // FIFO storage; contents are don't-care while the pointers are reset
  always_ff @(posedge sensor_clk) begin
    if (push)
      mem[wr_ptr] <= in_pixel;
  end

  // FIFO pointers, back-pressure, position counters and output register
  always_ff @(posedge sensor_clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready    <= 1'b0;
      overflow    <= 1'b0;
      col         <= '0;
      row         <= '0;
      active_mode <= MODE_BYPASS;
      active_thr  <= '0;
      prev_pixel  <= '0;
      out_valid   <= 1'b0;
      out_pixel   <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_last    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      in_ready <= (count_next <= READY_LVL);
      if (in_valid && !push)
        overflow <= 1'b1;

      frame_done <= out_valid && out_ready && out_last;

      if (pop) begin
        out_valid  <= 1'b1;
        out_pixel  <= result;
        out_sof    <= first_pix;
        out_eol    <= last_col;
        out_last   <= last_col && last_row;
        prev_pixel <= head;
        if (first_pix) begin
          active_mode <= mode_t'(mode);
          active_thr  <= threshold;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_processor.sv
// Directed self-checking bench for pixel_processor.
module tb_pixel_processor;

  logic       sensor_clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_pixel;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;
  logic       frame_done;
  logic       overflow;

  pixel_processor #(
    .IMAGE_WIDTH (32),
    .IMAGE_HEIGHT(32),
    .FIFO_DEPTH  (8)
  ) dut (
    .sensor_clk(sensor_clk),
    .rst_n     (rst_n),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .threshold (threshold),
    .out_pixel (out_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  always #5 sensor_clk = ~sensor_clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] thr;
    logic [7:0] pix;
    logic [7:0] exp;
    logic       sof;
    logic       eol;
  } vec_t;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
  } obs_t;

  vec_t vt[$];
  obs_t got_q[$];
  int   fd_log[$];
  int   hs_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Record every output handshake and every frame_done pulse
  always @(negedge sensor_clk) begin
    if (frame_done)
      fd_log.push_back(hs_cnt);
    if (out_valid && out_ready) begin
      got_q.push_back('{pix: out_pixel, sof: out_sof, eol: out_eol});
      hs_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic [7:0] thr, input logic [7:0] p,
                     input logic [7:0] e, input logic sof, input logic eol);
    vt.push_back('{mode: m, thr: thr, pix: p, exp: e, sof: sof, eol: eol});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge sensor_clk);
    rst_n = 1'b1;
    @(negedge sensor_clk);
  endtask

  task automatic wait_hs(input int base, input int n, input int budget);
    for (int w = 0; w < budget && got_q.size() < base + n; w++)
      @(negedge sensor_clk);
  endtask

  // Stream the table one pixel per cycle with out_ready high and compare in order
  task automatic run_vecs(input string name);
    int base;
    int n;
    base = got_q.size();
    n = vt.size();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      mode      = vt[i].mode;
      threshold = vt[i].thr;
      in_pixel  = vt[i].pix;
      in_valid  = 1'b1;
      @(negedge sensor_clk);
    end
    in_valid = 1'b0;
    wait_hs(base, n, 100);
    chk({name, "_count"}, 32'(got_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_q.size())
        chk($sformatf("%s_px%0d", name, i),
            {22'd0, got_q[base+i].sof, got_q[base+i].eol, got_q[base+i].pix},
            {22'd0, vt[i].sof, vt[i].eol, vt[i].exp});
    end
    vt.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    int fd_base;
    int hs_base;
    int sent;
    int drop_at;
    logic prev_rdy;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    mode      = 2'd0;
    threshold = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge sensor_clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pixel", 32'(out_pixel), 0);
    chk("rst_sof_eol", {30'd0, out_sof, out_eol}, 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge sensor_clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // Two-cycle latency from in_valid to out_valid
    in_valid = 1'b1;
    in_pixel = 8'hA5;
    @(negedge sensor_clk);
    in_valid = 1'b0;
    chk("lat_c1_valid", 32'(out_valid), 0);
    @(negedge sensor_clk);
    chk("lat_c2_out", {22'd0, out_valid, out_sof, out_pixel}, {22'd0, 1'b1, 1'b1, 8'hA5});

    // Bypass line 0x00..0x1F
    do_reset();
    for (int i = 0; i < 32; i++)
      add(2'd0, 8'h00, 8'(i), 8'(i), i == 0, i == 31);
    run_vecs("bypass");

    // Invert
    do_reset();
    add(2'd1, 8'h00, 8'h30, 8'hCF, 1'b1, 1'b0);
    add(2'd1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    add(2'd1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_vecs("invert");

    // Threshold at 0x80
    do_reset();
    add(2'd2, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0);
    add(2'd2, 8'h80, 8'h80, 8'hFF, 1'b0, 1'b0);
    add(2'd2, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add(2'd2, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
    run_vecs("thresh");

    // Horizontal gradient over a line boundary
    do_reset();
    add(2'd3, 8'h00, 8'd10, 8'd0, 1'b1, 1'b0);
    add(2'd3, 8'h00, 8'd20, 8'd10, 1'b0, 1'b0);
    add(2'd3, 8'h00, 8'd15, 8'd5, 1'b0, 1'b0);
    for (int i = 3; i < 32; i++)
      add(2'd3, 8'h00, 8'd15, 8'd0, 1'b0, i == 31);
    add(2'd3, 8'h00, 8'd100, 8'd0, 1'b0, 1'b0);
    add(2'd3, 8'h00, 8'd90, 8'd10, 1'b0, 1'b0);
    run_vecs("grad");

    // Back-pressure: producer honours in_ready with one cycle of lag
    do_reset();
    mode = 2'd0;
    out_ready = 1'b0;
    sent = 0;
    drop_at = -1;
    prev_rdy = in_ready;
    base = got_q.size();
    for (int k = 0; k < 20; k++) begin
      if (!in_ready && drop_at < 0)
        drop_at = sent;
      in_valid = prev_rdy;
      in_pixel = 8'(sent + 1);
      if (prev_rdy)
        sent++;
      prev_rdy = in_ready;
      @(negedge sensor_clk);
    end
    in_valid = 1'b0;
    chk("bp_sent_at_ready_drop", 32'(drop_at), 8);
    chk("bp_total_sent", 32'(sent), 9);
    chk("bp_overflow", 32'(overflow), 0);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_output_hold", {22'd0, out_valid, out_sof, out_pixel}, {22'd0, 1'b1, 1'b1, 8'h01});
    out_ready = 1'b1;
    wait_hs(base, 9, 50);
    chk("bp_drain_count", 32'(got_q.size() - base), 9);
    for (int i = 0; i < 9; i++)
      if (base + i < got_q.size())
        chk($sformatf("bp_px%0d", i), 32'(got_q[base+i].pix), 32'(i + 1));
    repeat (2) @(negedge sensor_clk);
    chk("bp_in_ready_back", 32'(in_ready), 1);

    // Mode change mid-frame takes effect next frame; frame_done per frame
    do_reset();
    fd_base = fd_log.size();
    hs_base = hs_cnt;
    for (int i = 0; i < 2048; i++)
      add((i >= 100) ? 2'd1 : 2'd0, 8'h00, 8'(i),
          (i < 1024) ? 8'(i) : ~8'(i), (i % 1024) == 0, (i % 32) == 31);
    run_vecs("frames");
    repeat (3) @(negedge sensor_clk);
    chk("fd_pulses", 32'(fd_log.size() - fd_base), 2);
    if (fd_log.size() - fd_base >= 2) begin
      chk("fd_first_after", 32'(fd_log[fd_base] - hs_base), 1024);
      chk("fd_second_after", 32'(fd_log[fd_base+1] - hs_base), 2048);
    end

    // Overflow: producer ignores in_ready into a stalled FIFO
    do_reset();
    mode = 2'd0;
    out_ready = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_pixel = 8'(i + 1);
      @(negedge sensor_clk);
    end
    in_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    out_ready = 1'b1;
    repeat (20) @(negedge sensor_clk);
    chk("ovf_drain_count", 32'(got_q.size() - base), 9);
    for (int i = 0; i < 9; i++)
      if (base + i < got_q.size())
        chk($sformatf("ovf_px%0d", i), 32'(got_q[base+i].pix), 32'(i + 1));
    chk("ovf_sticky", 32'(overflow), 1);

    // Reset mid-frame with pixels buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pixel = 8'(8'h20 + i);
      @(negedge sensor_clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge sensor_clk);
    chk("mrst_outputs",
        {21'd0, out_valid, out_sof, out_eol, out_pixel},
        32'd0);
    chk("mrst_flags", {29'd0, frame_done, overflow, in_ready}, 0);
    rst_n = 1'b1;
    @(negedge sensor_clk);
    base = got_q.size();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'h55;
    @(negedge sensor_clk);
    in_valid = 1'b0;
    repeat (6) @(negedge sensor_clk);
    chk("mrst_count", 32'(got_q.size() - base), 1);
    if (got_q.size() > base)
      chk("mrst_first", {22'd0, got_q[base].sof, got_q[base].eol, got_q[base].pix},
          {22'd0, 1'b1, 1'b0, 8'h55});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
